hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage core (FD, DE, EM, MW).
- Detects load-use hazards the DataForwardingUnit cannot cover, and sequences them with taken-branch flushes, instruction/data memory busy stalls and halt.
- Drives per-stage pipeline-register write enables and bubble/flush controls.
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_stall_controller_pkg.sv | 33 +++
 rtl/hazard_stall_controller_if.sv | 48 ++++
 rtl/hazard_stall_controller_sat_counter.sv | 26 ++
 rtl/hazard_stall_controller.sv | 168 ++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions: controller state encoding, specifier width,
// NOP encoding loaded by fd_flush/de_bubble consumers, stage-enable bundle.
package hazard_stall_controller_pkg;

  localparam int unsigned PIPE_REG_W = 3;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    PS_RUN     = 2'd0,
    PS_LDSTALL = 2'd1,
    PS_MEMWAIT = 2'd2,
    PS_HALTED  = 2'd3
  } pipe_state_e;

  localparam logic [STATE_W-1:0] ST_RUN     = PS_RUN;
  localparam logic [STATE_W-1:0] ST_LDSTALL = PS_LDSTALL;
  localparam logic [STATE_W-1:0] ST_MEMWAIT = PS_MEMWAIT;
  localparam logic [STATE_W-1:0] ST_HALTED  = PS_HALTED;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc;
    logic fd;
    logic de;
    logic em;
    logic mw;
  } stage_en_t;

  localparam stage_en_t EN_ALL  = stage_en_t'(5'b11111);
  localparam stage_en_t EN_NONE = stage_en_t'(5'b00000);

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side hazard inputs and controller-side stage controls/counters.
interface hazard_stall_controller_if
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned REG_W = PIPE_REG_W,
  parameter int unsigned CNT_W = 16
);

  logic [REG_W-1:0] Rs_FD;
  logic [REG_W-1:0] Rt_FD;
  logic             RsV_FD;
  logic             RtV_FD;
  logic [REG_W-1:0] Rd_DE;
  logic             RdV_DE;
  logic             RegWrite_DE;
  logic             ReadMem_DE;
  logic             branch_taken_DE;
  logic             imem_busy;
  logic             dmem_busy;
  logic             halt_MW;

  logic             pc_write;
  logic             fd_write;
  logic             de_write;
  logic             em_write;
  logic             mw_write;
  logic             pc_sel_branch;
  logic             fd_flush;
  logic             de_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs_FD, Rt_FD, RsV_FD, RtV_FD, Rd_DE, RdV_DE, RegWrite_DE, ReadMem_DE,
           branch_taken_DE, imem_busy, dmem_busy, halt_MW,
    input  pc_write, fd_write, de_write, em_write, mw_write, pc_sel_branch,
           fd_flush, de_bubble, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs_FD, Rt_FD, RsV_FD, RtV_FD, Rd_DE, RdV_DE, RegWrite_DE, ReadMem_DE,
           branch_taken_DE, imem_busy, dmem_busy, halt_MW,
    output pc_write, fd_write, de_write, em_write, mw_write, pc_sel_branch,
           fd_flush, de_bubble, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear, sticks at all-ones.
module hazard_stall_controller_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, memory
// busy freezes and halt, with saturating stall/flush performance counters.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned REG_W           = PIPE_REG_W,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hazard_stall_controller_if.slave bus
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] r_ret_state;
  logic [1:0]         r_bub_left;

  logic [STATE_W-1:0] w_state_nxt;
  logic [STATE_W-1:0] w_ret_nxt;
  logic [1:0]         w_bub_nxt;
  logic [STATE_W-1:0] w_eval_state;
  stage_en_t          w_en;
  logic               w_sel_branch;
  logic               w_fd_flush;
  logic               w_de_bubble;
  logic               w_flush_inc;
  logic               w_stall_inc;
  logic               w_load_use;
  logic [REG_W-1:0]   w_rs;
  logic [REG_W-1:0]   w_rt;
  logic [REG_W-1:0]   w_rd;
  logic [CNT_W-1:0]   w_stall_cnt;
  logic [CNT_W-1:0]   w_flush_cnt;

  assign w_rs = bus.Rs_FD;
  assign w_rt = bus.Rt_FD;
  assign w_rd = bus.Rd_DE;

  // Load in DE feeding a source of FD that forwarding cannot reach in time.
  assign w_load_use = bus.ReadMem_DE & bus.RegWrite_DE & bus.RdV_DE &
                      ((bus.RsV_FD & (w_rs == w_rd)) | (bus.RtV_FD & (w_rt == w_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_bub_left  <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_bub_left  <= w_bub_nxt;
    end
  end

  always_comb begin
    w_en         = EN_ALL;
    w_sel_branch = 1'b0;
    w_fd_flush   = 1'b0;
    w_de_bubble  = 1'b0;
    w_flush_inc  = 1'b0;
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret_state;
    w_bub_nxt    = r_bub_left;

    // The memory release cycle behaves as the interrupted state, with no gap.
    w_eval_state = r_state;
    if ((r_state == ST_MEMWAIT) && !bus.dmem_busy) begin
      w_eval_state = r_ret_state;
    end

    case (w_eval_state)
      ST_RUN: begin
        w_state_nxt = ST_RUN;
        if (bus.halt_MW) begin
          w_en        = EN_NONE;
          w_state_nxt = ST_HALTED;
        end else if (bus.dmem_busy) begin
          w_en        = EN_NONE;
          w_ret_nxt   = ST_RUN;
          w_state_nxt = ST_MEMWAIT;
        end else if (bus.branch_taken_DE) begin
          w_sel_branch = 1'b1;
          w_fd_flush   = 1'b1;
          w_de_bubble  = 1'b1;
          w_flush_inc  = 1'b1;
        end else if (w_load_use) begin
          w_en.pc     = 1'b0;
          w_en.fd     = 1'b0;
          w_de_bubble = 1'b1;
          if (LOAD_USE_CYCLES > 1) begin
            w_bub_nxt   = 2'(LOAD_USE_CYCLES - 1);
            w_state_nxt = ST_LDSTALL;
          end
        end else if (bus.imem_busy) begin
          w_en.pc    = 1'b0;
          w_fd_flush = 1'b1;
        end
      end

      ST_LDSTALL: begin
        w_state_nxt = ST_LDSTALL;
        if (bus.halt_MW) begin
          w_en        = EN_NONE;
          w_state_nxt = ST_HALTED;
        end else if (bus.dmem_busy) begin
          w_en        = EN_NONE;
          w_ret_nxt   = ST_LDSTALL;
          w_state_nxt = ST_MEMWAIT;
        end else begin
          w_en.pc     = 1'b0;
          w_en.fd     = 1'b0;
          w_de_bubble = 1'b1;
          if (r_bub_left <= 2'd1) begin
            w_bub_nxt   = 2'd0;
            w_state_nxt = ST_RUN;
          end else begin
            w_bub_nxt = r_bub_left - 2'd1;
          end
        end
      end

      ST_MEMWAIT: begin
        w_en = EN_NONE;
        if (bus.halt_MW) begin
          w_state_nxt = ST_HALTED;
        end
      end

      default: begin
        w_en = EN_NONE;
      end
    endcase
  end

  // Reset forces every control low regardless of the state registers.
  assign bus.pc_write      = rst_n & w_en.pc;
  assign bus.fd_write      = rst_n & w_en.fd;
  assign bus.de_write      = rst_n & w_en.de;
  assign bus.em_write      = rst_n & w_en.em;
  assign bus.mw_write      = rst_n & w_en.mw;
  assign bus.pc_sel_branch = rst_n & w_sel_branch;
  assign bus.fd_flush      = rst_n & w_fd_flush;
  assign bus.de_bubble     = rst_n & w_de_bubble;
  assign bus.halted        = rst_n & (r_state == ST_HALTED);

  assign w_stall_inc = rst_n & ~w_en.pc & (r_state != ST_HALTED);

  hazard_stall_controller_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall_inc),
    .i_clr (1'b0),
    .o_cnt (w_stall_cnt)
  );

  hazard_stall_controller_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (rst_n & w_flush_inc),
    .i_clr (1'b0),
    .o_cnt (w_flush_cnt)
  );

  assign bus.stall_cnt = w_stall_cnt;
  assign bus.flush_cnt = w_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: two controllers (1 and 2 load-use bubbles, wide and narrow
// counters) driven identically and compared against an abstract pipeline model.
module tb_hazard_stall_controller;

  typedef struct {
    logic       rst_n;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       rsv;
    logic       rtv;
    logic [2:0] rd;
    logic       rdv;
    logic       rw;
    logic       rm;
    logic       br;
    logic       imem;
    logic       dmem;
    logic       halt;
  } stim_t;

  typedef struct {
    logic [8:0] ctl;
    int         stall;
    int         flush;
  } exp_t;

  logic clk;
  logic rst_n;

  hazard_stall_controller_if #(.REG_W(3), .CNT_W(16)) bus_a ();
  hazard_stall_controller_if #(.REG_W(3), .CNT_W(4))  bus_b ();

  hazard_stall_controller #(.REG_W(3), .LOAD_USE_CYCLES(1), .CNT_W(16)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  hazard_stall_controller #(.REG_W(3), .LOAD_USE_CYCLES(2), .CNT_W(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t mon_a;
  exp_t mon_b;

  // Abstract model: outstanding bubble count, halted flag, two counters.
  int m_owed[2];
  bit m_halt[2];
  int m_stall[2];
  int m_flush[2];
  int m_bubbles[2] = '{1, 2};
  int m_max[2]     = '{65535, 15};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, rs: 3'd0, rt: 3'd0, rsv: 1'b0, rtv: 1'b0, rd: 3'd0,
          rdv: 1'b0, rw: 1'b0, rm: 1'b0, br: 1'b0, imem: 1'b0, dmem: 1'b0, halt: 1'b0};
    return s;
  endfunction

  task automatic model_step(input int d, input stim_t s, output exp_t e);
    logic pc, fd, de, em, mw, sel, ff, bub, hl;
    bit   lu;
    bit   was_halted;
    e.stall = m_stall[d];
    e.flush = m_flush[d];
    if (!s.rst_n) begin
      e.ctl      = '0;
      e.stall    = 0;
      e.flush    = 0;
      m_owed[d]  = 0;
      m_halt[d]  = 1'b0;
      m_stall[d] = 0;
      m_flush[d] = 0;
      return;
    end
    {pc, fd, de, em, mw} = 5'b11111;
    {sel, ff, bub, hl}   = 4'b0000;
    was_halted = m_halt[d];
    lu = s.rm && s.rw && s.rdv && ((s.rsv && s.rs == s.rd) || (s.rtv && s.rt == s.rd));
    if (was_halted) begin
      {pc, fd, de, em, mw} = 5'b00000;
      hl = 1'b1;
    end else if (s.halt) begin
      {pc, fd, de, em, mw} = 5'b00000;
      m_halt[d] = 1'b1;
    end else if (s.dmem) begin
      {pc, fd, de, em, mw} = 5'b00000;
    end else if (m_owed[d] > 0) begin
      pc = 1'b0; fd = 1'b0; bub = 1'b1;
      m_owed[d]--;
    end else if (s.br) begin
      sel = 1'b1; ff = 1'b1; bub = 1'b1;
      if (m_flush[d] < m_max[d]) m_flush[d]++;
    end else if (lu) begin
      pc = 1'b0; fd = 1'b0; bub = 1'b1;
      m_owed[d] = m_bubbles[d] - 1;
    end else if (s.imem) begin
      pc = 1'b0; ff = 1'b1;
    end
    if (!pc && !was_halted && m_stall[d] < m_max[d]) m_stall[d]++;
    e.ctl = {pc, fd, de, em, mw, sel, ff, bub, hl};
  endtask

  task automatic apply(input stim_t s);
    rst_n                 = s.rst_n;
    bus_a.Rs_FD           = s.rs;    bus_b.Rs_FD           = s.rs;
    bus_a.Rt_FD           = s.rt;    bus_b.Rt_FD           = s.rt;
    bus_a.RsV_FD          = s.rsv;   bus_b.RsV_FD          = s.rsv;
    bus_a.RtV_FD          = s.rtv;   bus_b.RtV_FD          = s.rtv;
    bus_a.Rd_DE           = s.rd;    bus_b.Rd_DE           = s.rd;
    bus_a.RdV_DE          = s.rdv;   bus_b.RdV_DE          = s.rdv;
    bus_a.RegWrite_DE     = s.rw;    bus_b.RegWrite_DE     = s.rw;
    bus_a.ReadMem_DE      = s.rm;    bus_b.ReadMem_DE      = s.rm;
    bus_a.branch_taken_DE = s.br;    bus_b.branch_taken_DE = s.br;
    bus_a.imem_busy       = s.imem;  bus_b.imem_busy       = s.imem;
    bus_a.dmem_busy       = s.dmem;  bus_b.dmem_busy       = s.dmem;
    bus_a.halt_MW         = s.halt;  bus_b.halt_MW         = s.halt;
  endtask

  task automatic step(input stim_t s);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    apply(s);
    model_step(0, s, ea);
    model_step(1, s, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    step(s);
  endtask

  // Monitor: outputs are settled mid-cycle, compare at the falling edge.
  always @(negedge clk) begin
    if (q_a.size() != 0) begin
      mon_a = q_a.pop_front();
      check("ctl_a", 32'({bus_a.pc_write, bus_a.fd_write, bus_a.de_write, bus_a.em_write,
                          bus_a.mw_write, bus_a.pc_sel_branch, bus_a.fd_flush,
                          bus_a.de_bubble, bus_a.halted}), 32'(mon_a.ctl));
      check("stall_cnt_a", 32'(bus_a.stall_cnt), mon_a.stall);
      check("flush_cnt_a", 32'(bus_a.flush_cnt), mon_a.flush);
    end
    if (q_b.size() != 0) begin
      mon_b = q_b.pop_front();
      check("ctl_b", 32'({bus_b.pc_write, bus_b.fd_write, bus_b.de_write, bus_b.em_write,
                          bus_b.mw_write, bus_b.pc_sel_branch, bus_b.fd_flush,
                          bus_b.de_bubble, bus_b.halted}), 32'(mon_b.ctl));
      check("stall_cnt_b", 32'(bus_b.stall_cnt), mon_b.stall);
      check("flush_cnt_b", 32'(bus_b.flush_cnt), mon_b.flush);
    end
  end

  initial begin
    stim_t s;
    int    halt_cycles;
    for (int d = 0; d < 2; d++) begin
      m_owed[d] = 0; m_halt[d] = 1'b0; m_stall[d] = 0; m_flush[d] = 0;
    end
    apply(idle());
    #1 rst_n = 1'b0;
    do_reset();
    do_reset();
    step(idle());

    // Load-use on Rs, then idle to see recovery.
    s = idle(); s.rm = 1; s.rw = 1; s.rdv = 1; s.rd = 3'd3; s.rs = 3'd3; s.rsv = 1;
    step(s); step(idle()); step(idle());

    // Rt match with its valid flag clear, and a load with no valid destination.
    s = idle(); s.rm = 1; s.rw = 1; s.rdv = 1; s.rd = 3'd5; s.rt = 3'd5; s.rtv = 0;
    s.rs = 3'd1; s.rsv = 1;
    step(s);
    s = idle(); s.rm = 1; s.rw = 1; s.rdv = 0; s.rd = 3'd2; s.rs = 3'd2; s.rsv = 1;
    step(s);
    s = idle(); s.rm = 1; s.rw = 1; s.rdv = 1; s.rd = 3'd0; s.rs = 3'd0; s.rsv = 0;
    step(s); step(idle());

    // Load-use followed by a three-cycle data-memory stall.
    do_reset();
    s = idle(); s.rm = 1; s.rw = 1; s.rdv = 1; s.rd = 3'd3; s.rs = 3'd3; s.rsv = 1;
    step(s);
    s = idle(); s.dmem = 1;
    repeat (3) step(s);
    step(idle()); step(idle()); step(idle());

    // Branch and load-use together: the branch wins.
    do_reset();
    s = idle(); s.br = 1; s.rm = 1; s.rw = 1; s.rdv = 1; s.rd = 3'd4; s.rt = 3'd4; s.rtv = 1;
    step(s); step(idle()); step(idle());

    // Two instruction-memory busy cycles.
    s = idle(); s.imem = 1;
    step(s); step(s); step(idle());

    // Halt, stay halted, reset mid-halt, resume.
    s = idle(); s.halt = 1;
    step(s);
    s = idle(); s.br = 1; s.imem = 1;
    repeat (4) step(s);
    do_reset();
    step(idle()); step(idle());

    // Randomised traffic with occasional halts and resets.
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      s      = idle();
      s.rs   = 3'($urandom_range(0, 3));
      s.rt   = 3'($urandom_range(0, 3));
      s.rd   = 3'($urandom_range(0, 3));
      s.rsv  = ($urandom_range(0, 3) != 0);
      s.rtv  = ($urandom_range(0, 3) != 0);
      s.rdv  = ($urandom_range(0, 3) != 0);
      s.rw   = ($urandom_range(0, 3) != 0);
      s.rm   = ($urandom_range(0, 1) != 0);
      s.br   = ($urandom_range(0, 5) == 0);
      s.imem = ($urandom_range(0, 5) == 0);
      s.dmem = ($urandom_range(0, 6) == 0);
      s.halt = ($urandom_range(0, 199) == 0);
      halt_cycles = m_halt[0] ? halt_cycles + 1 : 0;
      if (halt_cycles > 4 || $urandom_range(0, 299) == 0) begin
        s.rst_n = 1'b0;
      end
      step(s);
    end

    @(negedge clk);
    #1;
    check("drain_a", 32'(q_a.size()), 32'd0);
    check("drain_b", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
